// File: rtl/nwc_pkg.sv
// Shared constants and state type for the negacyclic-convolution job sequencer.
package nwc_pkg;

    localparam int unsigned COEF_W  = 30;
    localparam int unsigned DATA_W  = 2 * COEF_W;
    localparam int unsigned N_WORDS = 2048;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        RUN,
        FINISH
    } seq_state_t;

endpackage

// File: rtl/nwc_job_sequencer.sv
// Sequences one job through nwc_processor: operand load, single start pulse,
// result forwarding with last marker, completion pulse, job counter and watchdog.
module nwc_job_sequencer
    import nwc_pkg::*;
#(
    parameter int unsigned DATA_W  = nwc_pkg::DATA_W,
    parameter int unsigned N_WORDS = nwc_pkg::N_WORDS,
    parameter int unsigned TIMEOUT = 65536
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              go,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data0,
    input  logic [DATA_W-1:0] in_data1,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic              timeout_err,
    output logic              proto_err,
    output logic [15:0]       job_cnt,
    output logic [DATA_W-1:0] proc_data_in0,
    output logic [DATA_W-1:0] proc_data_in1,
    output logic              proc_write_enable,
    output logic              proc_start,
    input  logic [DATA_W-1:0] proc_data_out,
    input  logic              proc_output_active,
    input  logic              proc_ready
);

    localparam int unsigned CNT_W = $clog2(N_WORDS);
    localparam int unsigned WD_W  = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_WORDS - 1);

    seq_state_t state_q, state_d;

    logic [CNT_W-1:0]  load_cnt_q, load_cnt_d;
    logic [CNT_W-1:0]  out_cnt_q, out_cnt_d;
    logic [WD_W-1:0]   wd_cnt_q, wd_cnt_d;
    logic [DATA_W-1:0] din0_q, din1_q, out_data_q;
    logic [15:0]       job_cnt_q;
    logic              we_q, start_q, start_d, out_valid_q, out_last_q;
    logic              timeout_err_q, proto_err_q;

    logic go_ok, accept, run_active, wd_expire;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (go_ok) state_d = LOAD;
            LOAD:    if (accept && (load_cnt_q == LAST_IDX)) state_d = START;
            START:   if (proc_ready) state_d = RUN;
            RUN: begin
                if (run_active && (out_cnt_q == LAST_IDX)) state_d = FINISH;
                else if (wd_expire)                        state_d = IDLE;
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready   = (state_q == LOAD);
        busy       = (state_q != IDLE);
        done       = (state_q == FINISH);
        go_ok      = (state_q == IDLE) && go && proc_ready;
        start_d    = (state_q == START) && proc_ready;
        accept     = in_valid && in_ready;
        run_active = (state_q == RUN) && proc_output_active;
        wd_expire  = (state_q == RUN) && !proc_output_active
                     && (wd_cnt_q == WD_W'(TIMEOUT - 1));
    end

    always_comb begin
        load_cnt_d = load_cnt_q;
        if (go_ok)       load_cnt_d = '0;
        else if (accept) load_cnt_d = load_cnt_q + 1'b1;

        out_cnt_d = out_cnt_q;
        if (state_q == START) out_cnt_d = '0;
        else if (run_active)  out_cnt_d = out_cnt_q + 1'b1;

        // Watchdog only advances on idle RUN cycles; anything else rearms it.
        wd_cnt_d = '0;
        if ((state_q == RUN) && !proc_output_active) wd_cnt_d = wd_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            load_cnt_q    <= '0;
            out_cnt_q     <= '0;
            wd_cnt_q      <= '0;
            din0_q        <= '0;
            din1_q        <= '0;
            we_q          <= 1'b0;
            start_q       <= 1'b0;
            out_valid_q   <= 1'b0;
            out_last_q    <= 1'b0;
            out_data_q    <= '0;
            job_cnt_q     <= '0;
            timeout_err_q <= 1'b0;
            proto_err_q   <= 1'b0;
        end else begin
            load_cnt_q  <= load_cnt_d;
            out_cnt_q   <= out_cnt_d;
            wd_cnt_q    <= wd_cnt_d;
            we_q        <= accept;
            start_q     <= start_d;
            out_valid_q <= run_active;
            out_last_q  <= run_active && (out_cnt_q == LAST_IDX);
            if (accept) begin
                din0_q <= in_data0;
                din1_q <= in_data1;
            end
            if (run_active)         out_data_q <= proc_data_out;
            if (state_q == FINISH)  job_cnt_q  <= job_cnt_q + 16'd1;
            if (go_ok)              timeout_err_q <= 1'b0;
            else if (wd_expire)     timeout_err_q <= 1'b1;
            if (proc_output_active && (state_q != RUN)) proto_err_q <= 1'b1;
            else if (go_ok)                             proto_err_q <= 1'b0;
        end
    end

    assign out_valid         = out_valid_q;
    assign out_data          = out_data_q;
    assign out_last          = out_last_q;
    assign timeout_err       = timeout_err_q;
    assign proto_err         = proto_err_q;
    assign job_cnt           = job_cnt_q;
    assign proc_data_in0     = din0_q;
    assign proc_data_in1     = din1_q;
    assign proc_write_enable = we_q;
    assign proc_start        = start_q;

endmodule

// File: tb/tb_nwc_job_sequencer.sv
// Directed self-checking bench for nwc_job_sequencer with a simple processor model.
module tb_nwc_job_sequencer;

    localparam int unsigned DW = 60;
    localparam int unsigned N  = 2048;
    localparam int unsigned TO = 100;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          go = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data0 = '0;
    logic [DW-1:0] in_data1 = '0;
    logic [DW-1:0] proc_data_out = '0;
    logic          proc_output_active = 1'b0;
    logic          proc_ready = 1'b1;

    logic          in_ready, out_valid, out_last, busy, done;
    logic          timeout_err, proto_err, proc_write_enable, proc_start;
    logic [DW-1:0] out_data, proc_data_in0, proc_data_in1;
    logic [15:0]   job_cnt;

    int unsigned n_checks = 0;
    int unsigned n_pass = 0;

    always #5 clk = ~clk;

    nwc_job_sequencer #(
        .DATA_W (DW),
        .N_WORDS(N),
        .TIMEOUT(TO)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .go                (go),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_data0          (in_data0),
        .in_data1          (in_data1),
        .out_valid         (out_valid),
        .out_data          (out_data),
        .out_last          (out_last),
        .busy              (busy),
        .done              (done),
        .timeout_err       (timeout_err),
        .proto_err         (proto_err),
        .job_cnt           (job_cnt),
        .proc_data_in0     (proc_data_in0),
        .proc_data_in1     (proc_data_in1),
        .proc_write_enable (proc_write_enable),
        .proc_start        (proc_start),
        .proc_data_out     (proc_data_out),
        .proc_output_active(proc_output_active),
        .proc_ready        (proc_ready)
    );

    function automatic logic [DW-1:0] a_word(input int unsigned i);
        return {30'(i), 30'(i * 7 + 3)};
    endfunction

    function automatic logic [DW-1:0] b_word(input int unsigned i);
        return {30'(i * 5 + 1), 30'(~i)};
    endfunction

    function automatic logic [DW-1:0] r_word(input int unsigned i, input int unsigned job);
        return {30'(i ^ (job * 1000)), 30'(i + 12345)};
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; go = 1'b1; in_valid = 1'b1; proc_output_active = 1'b1;
        proc_data_out = '1;
        repeat (3) step;
        go = 1'b0; in_valid = 1'b0; proc_output_active = 1'b0; proc_data_out = '0;
        n_checks++;
        if ({in_ready, out_valid, out_data, out_last, busy, done, timeout_err, proto_err,
             job_cnt, proc_data_in0, proc_data_in1, proc_write_enable, proc_start} !== '0)
            $display("FAIL reset_outputs: busy=%b in_ready=%b job_cnt=%0d proto_err=%b want all 0",
                     busy, in_ready, job_cnt, proto_err);
        else n_pass++;
        rst_n = 1'b1;
        step;
        n_checks++;
        if ({busy, in_ready, proc_start} !== 3'b000)
            $display("FAIL reset_release: busy/in_ready/start=%b want 000", {busy, in_ready, proc_start});
        else n_pass++;
    endtask

    // Accepted go, full operand load, then the single start pulse.
    task automatic do_load(input bit gapped, input int unsigned hold);
        int unsigned k;
        int unsigned c;
        int unsigned rdy;
        bit acc;
        k = 0; c = 0; rdy = 0;
        proc_ready = (hold == 0);
        proc_ready = 1'b1;
        go = 1'b1;
        step;
        go = 1'b0;
        if (hold != 0) proc_ready = 1'b0;
        n_checks++;
        if ({busy, in_ready, timeout_err, proto_err} !== 4'b1100)
            $display("FAIL go_accept: busy/in_ready/terr/perr=%b want 1100",
                     {busy, in_ready, timeout_err, proto_err});
        else n_pass++;
        while (k < N && c < 5000) begin
            in_valid = gapped ? (c % 2 == 0) : 1'b1;
            in_data0 = in_valid ? a_word(k) : '1;
            in_data1 = in_valid ? b_word(k) : '1;
            go = gapped && (c == 5);
            acc = in_valid && in_ready;
            if (in_ready) rdy++;
            step;
            n_checks++;
            if (proc_write_enable !== acc || proc_start !== 1'b0)
                $display("FAIL load_we c=%0d: we=%b start=%b want we=%b start=0",
                         c, proc_write_enable, proc_start, acc);
            else n_pass++;
            if (acc) begin
                n_checks++;
                if (proc_data_in0 !== a_word(k) || proc_data_in1 !== b_word(k))
                    $display("FAIL load_data k=%0d: got %h/%h want %h/%h",
                             k, proc_data_in0, proc_data_in1, a_word(k), b_word(k));
                else n_pass++;
                k++;
            end else if (k > 0) begin
                n_checks++;
                if (proc_data_in0 !== a_word(k - 1))
                    $display("FAIL load_hold k=%0d: got %h want %h", k, proc_data_in0, a_word(k - 1));
                else n_pass++;
            end
            c++;
        end
        in_valid = 1'b0; go = 1'b0; in_data0 = '0; in_data1 = '0;
        n_checks++;
        if (k != N) $display("FAIL load_words: accepted %0d want %0d", k, N);
        else n_pass++;
        n_checks++;
        if (rdy != (gapped ? 2 * N - 1 : N))
            $display("FAIL ready_cycles: got %0d want %0d", rdy, gapped ? 2 * N - 1 : N);
        else n_pass++;
        n_checks++;
        if ({in_ready, busy} !== 2'b01)
            $display("FAIL ready_drop: in_ready/busy=%b want 01", {in_ready, busy});
        else n_pass++;
        for (int h = 0; h < int'(hold); h++) begin
            step;
            n_checks++;
            if ({proc_start, busy} !== 2'b01)
                $display("FAIL start_wait h=%0d: start/busy=%b want 01", h, {proc_start, busy});
            else n_pass++;
        end
        proc_ready = 1'b1;
        step;
        n_checks++;
        if ({proc_start, proc_write_enable} !== 2'b10)
            $display("FAIL start_pulse: start/we=%b want 10", {proc_start, proc_write_enable});
        else n_pass++;
        step;
        n_checks++;
        if (proc_start !== 1'b0) $display("FAIL start_single: start=%b want 0", proc_start);
        else n_pass++;
    endtask

    // Processor model: emits n_emit result words, optionally with single-cycle gaps.
    task automatic do_outputs(input int unsigned n_emit, input bit gapped,
                              input int unsigned job, input bit finish, input int unsigned exp_jobs);
        bit lst;
        repeat (3) begin
            step;
            n_checks++;
            if (out_valid !== 1'b0) $display("FAIL run_quiet: out_valid=%b want 0", out_valid);
            else n_pass++;
        end
        for (int unsigned j = 0; j < n_emit; j++) begin
            proc_output_active = 1'b1;
            proc_data_out = r_word(j, job);
            lst = (j == N - 1);
            step;
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== r_word(j, job) || out_last !== lst || done !== lst)
                $display("FAIL out_word j=%0d: v=%b d=%h last=%b done=%b want v=1 d=%h last=%b done=%b",
                         j, out_valid, out_data, out_last, done, r_word(j, job), lst, lst);
            else n_pass++;
            if (gapped && (j % 3 == 0) && !lst) begin
                proc_output_active = 1'b0;
                proc_data_out = '1;
                step;
                n_checks++;
                if ({out_valid, done} !== 2'b00)
                    $display("FAIL out_gap j=%0d: v/done=%b want 00", j, {out_valid, done});
                else n_pass++;
            end
        end
        proc_output_active = 1'b0;
        proc_data_out = '0;
        if (finish) begin
            step;
            n_checks++;
            if ({done, busy, out_valid, out_last} !== 4'b0000 || job_cnt !== 16'(exp_jobs))
                $display("FAIL job_end: done/busy/v/last=%b job_cnt=%0d want 0000 job_cnt=%0d",
                         {done, busy, out_valid, out_last}, job_cnt, exp_jobs);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back;
        do_load(1'b0, 0);
        do_outputs(N, 1'b0, 1, 1'b1, 1);
    endtask

    task automatic test_gapped_stall;
        do_load(1'b1, 10);
        do_outputs(N, 1'b1, 2, 1'b1, 2);
    endtask

    task automatic test_proto_and_ignore;
        proc_output_active = 1'b1;
        proc_data_out = r_word(7, 9);
        step;
        proc_output_active = 1'b0;
        n_checks++;
        if ({proto_err, out_valid, busy} !== 3'b100)
            $display("FAIL proto_set: perr/v/busy=%b want 100", {proto_err, out_valid, busy});
        else n_pass++;
        step;
        n_checks++;
        if ({proto_err, out_valid} !== 2'b10)
            $display("FAIL proto_sticky: perr/v=%b want 10", {proto_err, out_valid});
        else n_pass++;
        proc_ready = 1'b0;
        go = 1'b1;
        step;
        go = 1'b0;
        proc_ready = 1'b1;
        n_checks++;
        if ({busy, proto_err} !== 2'b01)
            $display("FAIL go_not_ready: busy/perr=%b want 01", {busy, proto_err});
        else n_pass++;
    endtask

    task automatic test_timeout;
        do_load(1'b0, 0);
        do_outputs(5, 1'b0, 3, 1'b0, 0);
        for (int unsigned s = 1; s <= TO; s++) begin
            step;
            n_checks++;
            if (s < TO) begin
                if ({timeout_err, busy, done} !== 3'b010)
                    $display("FAIL wd_wait s=%0d: terr/busy/done=%b want 010", s, {timeout_err, busy, done});
                else n_pass++;
            end else begin
                if ({timeout_err, busy, done} !== 3'b100 || job_cnt !== 16'd2)
                    $display("FAIL wd_expire: terr/busy/done=%b job_cnt=%0d want 100 job_cnt=2",
                             {timeout_err, busy, done}, job_cnt);
                else n_pass++;
            end
        end
        step;
        n_checks++;
        if ({timeout_err, done} !== 2'b10) $display("FAIL wd_sticky: terr/done=%b want 10", {timeout_err, done});
        else n_pass++;
        go = 1'b1;
        step;
        go = 1'b0;
        n_checks++;
        if ({timeout_err, busy} !== 2'b01)
            $display("FAIL wd_clear: terr/busy=%b want 01", {timeout_err, busy});
        else n_pass++;
    endtask

    task automatic test_reset_mid_load;
        in_valid = 1'b1;
        for (int unsigned i = 0; i < 10; i++) begin
            in_data0 = a_word(i);
            in_data1 = b_word(i);
            step;
        end
        rst_n = 1'b0;
        step;
        rst_n = 1'b1;
        in_valid = 1'b0;
        n_checks++;
        if ({in_ready, out_valid, out_data, out_last, busy, done, timeout_err, proto_err,
             job_cnt, proc_data_in0, proc_data_in1, proc_write_enable, proc_start} !== '0)
            $display("FAIL midload_reset: busy=%b we=%b din0=%h job_cnt=%0d want all 0",
                     busy, proc_write_enable, proc_data_in0, job_cnt);
        else n_pass++;
        step;
        do_load(1'b0, 0);
        do_outputs(N, 1'b0, 4, 1'b1, 1);
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_gapped_stall();
        test_proto_and_ignore();
        test_timeout();
        test_reset_mid_load();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL global_timeout: bench did not complete, %0d/%0d so far", n_pass, n_checks);
        $fatal(1, "bench time limit exceeded");
    end

endmodule
